// File: rtl/tl_pkg.sv
// Shared traffic-light types: the sequencer's light code and the
// pedestrian crossing controller's state encoding.
package tl_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } t_light;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RED = 2'd1,
    WALK     = 2'd2,
    FLASH    = 2'd3
  } t_ped_state;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ped_flash_gen.sv
// Flashing DON'T-WALK pattern: a period counter plus a toggle flop that
// starts high on clear and inverts every FLASH_PERIOD enabled cycles.
module ped_flash_gen #(
  parameter int FLASH_PERIOD = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic dont_walk_o
);

  localparam int PH_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic            toggle_q, toggle_d;

  always_comb begin
    phase_d  = phase_q;
    toggle_d = toggle_q;
    if (clear_i) begin
      phase_d  = '0;
      toggle_d = 1'b1;
    end else if (enable_i) begin
      if (phase_q == PH_W'(FLASH_PERIOD - 1)) begin
        phase_d  = '0;
        toggle_d = ~toggle_q;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= '0;
      toggle_q <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      toggle_q <= toggle_d;
    end
  end

  assign dont_walk_o = toggle_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: latches button requests, grants WALK on a
// fresh RED entry, follows it with a flashing clearance, and holds RED meanwhile.
module ped_crossing_ctrl
  import tl_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6,
  parameter int FLASH_PERIOD = 2,
  localparam int CNT_W = $clog2(max_int(WALK_CYCLES, FLASH_CYCLES) + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       light_in,
  input  logic             button,
  output logic             walk,
  output logic             dont_walk,
  output logic             hold_red,
  output logic             req_pending,
  output logic [CNT_W-1:0] countdown,
  output logic             conflict
);

  t_ped_state       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             conflict_q, conflict_d;
  logic [1:0]       prev_light_q;
  logic             light_red, red_entry;
  logic             flash_clear, flash_enable, flash_dw;

  assign light_red = (light_in == RED);
  assign red_entry = light_red && (prev_light_q != RED);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q | button;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (button) state_d = WAIT_RED;
      end
      WAIT_RED: begin
        if (red_entry) begin
          state_d = WALK;
          cnt_d   = CNT_W'(WALK_CYCLES);
          req_d   = 1'b0;
        end
      end
      WALK, FLASH: begin
        // Losing RED mid-crossing aborts the grant; pending requests survive.
        if (!light_red) begin
          conflict_d = 1'b1;
          cnt_d      = '0;
          state_d    = (req_q || button) ? WAIT_RED : IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          if (state_q == WALK) begin
            state_d = FLASH;
            cnt_d   = CNT_W'(FLASH_CYCLES);
          end else begin
            state_d = (req_q || button) ? WAIT_RED : IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      conflict_q   <= 1'b0;
      prev_light_q <= RED;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      conflict_q   <= conflict_d;
      prev_light_q <= light_in;
    end
  end

  assign flash_clear  = (state_d == FLASH) && (state_q != FLASH);
  assign flash_enable = (state_d == FLASH) && (state_q == FLASH);

  ped_flash_gen #(
    .FLASH_PERIOD(FLASH_PERIOD)
  ) u_flash_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (flash_clear),
    .enable_i   (flash_enable),
    .dont_walk_o(flash_dw)
  );

  assign walk        = (state_q == WALK);
  assign hold_red    = (state_q == WALK) || (state_q == FLASH);
  assign dont_walk   = (state_q == WALK) ? 1'b0 : ((state_q == FLASH) ? flash_dw : 1'b1);
  assign countdown   = cnt_q;
  assign req_pending = req_q;
  assign conflict    = conflict_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scoreboard bench for ped_crossing_ctrl with WALK=4, FLASH=4, period 2:
// each driven cycle queues its expected outputs, which are popped after the edge.
module tb_ped_crossing_ctrl;
  import tl_pkg::*;

  typedef struct packed {
    logic       walk;
    logic       dw;
    logic       hr;
    logic       rp;
    logic [2:0] cd;
    logic       cf;
  } t_exp;

  logic       clk;
  logic       reset_n;
  logic [1:0] light_in;
  logic       button;
  logic       walk, dont_walk, hold_red, req_pending, conflict;
  logic [2:0] countdown;

  int   checkCount = 0;
  int   passCount  = 0;
  t_exp expQ[$];

  ped_crossing_ctrl #(
    .WALK_CYCLES (4),
    .FLASH_CYCLES(4),
    .FLASH_PERIOD(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .light_in   (light_in),
    .button     (button),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .hold_red   (hold_red),
    .req_pending(req_pending),
    .countdown  (countdown),
    .conflict   (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic t_exp mk(input logic w, input logic dw, input logic hr,
                              input logic rp, input int cd, input logic cf);
    t_exp e;
    e.walk = w;
    e.dw   = dw;
    e.hr   = hr;
    e.rp   = rp;
    e.cd   = 3'(cd);
    e.cf   = cf;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic sampleAndCheck(input string tag);
    t_exp e;
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 0, 1);
      return;
    end
    e = expQ.pop_front();
    checkOutput({tag, ".walk"},        walk,        e.walk);
    checkOutput({tag, ".dont_walk"},   dont_walk,   e.dw);
    checkOutput({tag, ".hold_red"},    hold_red,    e.hr);
    checkOutput({tag, ".req_pending"}, req_pending, e.rp);
    checkOutput({tag, ".countdown"},   countdown,   e.cd);
    checkOutput({tag, ".conflict"},    conflict,    e.cf);
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] l,
                               input logic b, input t_exp e);
    @(negedge clk);
    light_in = l;
    button   = b;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    sampleAndCheck(tag);
  endtask

  // Remaining WALK cycles (countdown 3..1), FLASH (4..1 with dont_walk 1,1,0,0),
  // then the idle/wait cycle; an optional press lands on the first step.
  task automatic walkFlashTail(input string tag, input logic btnFirst);
    for (int i = 3; i >= 1; i--)
      applyStimulus($sformatf("%s.walk%0d", tag, i), RED, (i == 3) ? btnFirst : 1'b0,
                    mk(1'b1, 1'b0, 1'b1, btnFirst, i, 1'b0));
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("%s.flash%0d", tag, 4 - i), RED, 1'b0,
                    mk(1'b0, (i < 2), 1'b1, btnFirst, 4 - i, 1'b0));
    applyStimulus({tag, ".end"}, RED, 1'b0, mk(1'b0, 1'b1, 1'b0, btnFirst, 0, 1'b0));
  endtask

  initial begin
    reset_n  = 1'b0;
    light_in = RED;
    button   = 1'b0;
    #2;
    expQ.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));
    sampleAndCheck("s0.reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Already red out of reset: never a grant.
    for (int i = 0; i < 10; i++)
      applyStimulus($sformatf("s0.idle%0d", i), RED, 1'b0,
                    mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));

    // Press on GREEN, then YELLOW -> RED grants the full crossing.
    applyStimulus("s1.press",  GREEN,  1'b1, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s1.yellow", YELLOW, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s1.entry",  RED,    1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0));
    walkFlashTail("s1", 1'b0);

    // Press while already RED waits for the next fresh entry.
    applyStimulus("s2.press",  RED,    1'b1, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s2.red1",   RED,    1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s2.red2",   RED,    1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s2.green",  GREEN,  1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s2.yellow", YELLOW, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s2.entry",  RED,    1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0));
    walkFlashTail("s2", 1'b0);

    // Press during WALK is served on the following RED entry.
    applyStimulus("s3.press",  GREEN,  1'b1, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s3.entry",  RED,    1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0));
    walkFlashTail("s3", 1'b1);
    applyStimulus("s3.hold",   RED,    1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s3.green",  GREEN,  1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s3.entry2", RED,    1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0));
    walkFlashTail("s3b", 1'b0);

    // Light leaves RED in the second WALK cycle.
    applyStimulus("s4.press",  GREEN,  1'b1, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s4.entry",  RED,    1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0));
    applyStimulus("s4.walk3",  RED,    1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0));
    applyStimulus("s4.abort",  GREEN,  1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1));
    applyStimulus("s4.after",  GREEN,  1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));
    applyStimulus("s4.yellow", YELLOW, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));
    applyStimulus("s4.idle",   RED,    1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));

    // Asynchronous reset in the middle of FLASH.
    applyStimulus("s5.press",  GREEN,  1'b1, mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0));
    applyStimulus("s5.entry",  RED,    1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0));
    for (int i = 3; i >= 1; i--)
      applyStimulus($sformatf("s5.walk%0d", i), RED, 1'b0,
                    mk(1'b1, 1'b0, 1'b1, 1'b0, i, 1'b0));
    applyStimulus("s5.flash4", RED, 1'b0, mk(1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b0));
    applyStimulus("s5.flash3", RED, 1'b0, mk(1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b0));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    expQ.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));
    sampleAndCheck("s5.reset");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("s5.green",  GREEN,  1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));
    applyStimulus("s5.yellow", YELLOW, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));
    applyStimulus("s5.red",    RED,    1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));
    applyStimulus("s5.red2",   RED,    1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian crossing controller that sits directly downstream of the traffic-light sequencer and consumes its 2-bit light code. It latches pedestrian button requests and grants a timed WALK phase only on a fresh entry into RED. It follows the WALK phase with a flashing don't-walk clearance phase. While it owns the crossing it asserts `hold_red` back to the sequencer, and it flags any case where the light leaves RED mid-crossing.

## Interface
- `WALK_CYCLES`, 8: length of the WALK phase in clock cycles; must be ≥1.
- `FLASH_CYCLES`, 6: length of the flashing clearance phase in cycles; must be ≥1.
- `FLASH_PERIOD`, 2: cycles between `dont_walk` toggles during FLASH; must be ≥1.
- `CNT_W`, localparam: `$clog2(max(WALK_CYCLES,FLASH_CYCLES)+1)`.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `light_in`  in  2  light code from the sequencer (`t_light`); code 3 is treated as not-RED.
- `button`  in  1  synchronous pedestrian request; a level held high counts once per cycle.
- `walk`  out  1  WALK lamp.
- `dont_walk`  out  1  DON'T-WALK lamp; steady or flashing.
- `hold_red`  out  1  request to the sequencer to stay in RED.
- `req_pending`  out  1  a request is latched but not yet served.
- `countdown`  out  CNT_W  cycles remaining in the current phase, including the current cycle.
- `conflict`  out  1  one-cycle pulse when the light leaves RED during WALK or FLASH.

## Operation
- States: IDLE, WAIT_RED, WALK, FLASH.
- `red_entry` is true when `light_in == RED` and the registered previous light (`prev_light`) is not RED.
- `prev_light` resets to RED, so a crossing that is already red at reset never grants WALK.
- IDLE:
  - `button` → WAIT_RED and set `req_pending`.
- WAIT_RED:
  - `red_entry` → WALK, load the counter with `WALK_CYCLES`, clear `req_pending`.
  - A press made while the light is already RED waits for the next fresh RED entry.
- WALK:
  - `walk=1`, `dont_walk=0`, `hold_red=1`.
  - The counter decrements each cycle.
  - When `countdown==1`, the next state is FLASH with the counter loaded to `FLASH_CYCLES`.
- FLASH:
  - `walk=0`, `hold_red=1`.
  - `dont_walk` starts at 1 and inverts every `FLASH_PERIOD` cycles, using an internal phase counter cleared on FLASH entry.
  - When `countdown==1`, the next state is WAIT_RED if `req_pending` is set (or `button` is high this cycle), otherwise IDLE.
- IDLE and WAIT_RED: `walk=0`, `dont_walk=1`, `hold_red=0`, `countdown=0`.
- `button` during WALK or FLASH sets `req_pending`. That request is served on a later RED entry, never by extending the current grant.
- Conflict: `light_in != RED` while in WALK or FLASH has the following effects on the next edge:
  - `conflict` pulses for one cycle.
  - `walk` drops to 0 and `dont_walk` goes to 1.
  - `hold_red` drops to 0.
  - The state goes to WAIT_RED if `req_pending` is set, else IDLE.
  - A concurrent `button` is latched.
- Reset values: `walk=0`, `dont_walk=1`, `hold_red=0`, `req_pending=0`, `countdown=0`, `conflict=0`, state IDLE.

## Timing
- All outputs are registered, decoded from next-state at the clock edge.
- Button → `req_pending`: visible after the edge that samples `button`, so 1-cycle latency.
- RED entry → `walk`: the edge that samples `light_in==RED` with `prev_light!=RED` makes `walk=1`, `hold_red=1` and `countdown=WALK_CYCLES` visible immediately after that edge.
- WALK is high for exactly `WALK_CYCLES` cycles. FLASH lasts exactly `FLASH_CYCLES` cycles. `hold_red` is high for `WALK_CYCLES+FLASH_CYCLES` cycles with no gap.
- `countdown` steps N…1 in each phase, then reloads or goes to 0.
- Reset deassertion is synchronous to `clk` upstream. Asserting `reset_n` mid-WALK immediately forces all outputs to their reset values.
- Simultaneous `button` and `red_entry` in IDLE: go to WAIT_RED only. WALK needs a later RED entry, because the request was not latched before the entry.

## Structure
- Package `tl_pkg` holds:
  - `t_light` enum logic[1:0] {GREEN=0, YELLOW=1, RED=2}, shared with the sequencer;
  - `t_ped_state` enum {IDLE, WAIT_RED, WALK, FLASH}.
- One sub-module, `ped_flash_gen`: period counter plus toggle flop, with enable and clear inputs, generating the FLASH `dont_walk` pattern.

## Test plan
Parameters for all scenarios: `WALK_CYCLES=4`, `FLASH_CYCLES=4`, `FLASH_PERIOD=2`.
- Reset with `light_in=RED`, no button, 10 cycles → `walk=0`, `dont_walk=1`, `hold_red=0`, `countdown=0` throughout.
- Button pulse during GREEN, then YELLOW→RED → `walk=1` for 4 cycles with countdown 4,3,2,1; then FLASH with `dont_walk` 1,1,0,0 and countdown 4,3,2,1; `hold_red` high for exactly 8 cycles.
- Button pressed while already RED → no WALK until the light cycles GREEN→YELLOW→RED; `req_pending` stays 1 until that entry.
- Button during WALK → after FLASH the state is WAIT_RED with `req_pending=1`; the second grant occurs on the next RED entry.
- `light_in` forced to GREEN in cycle 2 of WALK → `conflict` pulses 1 cycle, `walk=0`, `dont_walk=1`, `hold_red=0` on the next edge, state IDLE.
- `reset_n` asserted mid-FLASH → all outputs return to their reset values asynchronously, and a later RED entry without a new button produces no WALK.
